// File: rtl/pin_chain_pkg.sv
// rtl/pin_chain_pkg.sv - shared types, sizes and pattern generator for the pin chain tester
package pin_chain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } chain_state_e;

  localparam int N_CHAIN_PINS = 17;

  // Steps 0..n-1 walk a single one across the low n bits; steps n..2n-1
  // walk a single zero across the same bits. Bits at or above n stay 0.
  function automatic logic [N_CHAIN_PINS-1:0] pattern(input int unsigned k, input int unsigned n);
    logic [N_CHAIN_PINS-1:0] word;
    word = '0;
    for (int unsigned i = 0; i < N_CHAIN_PINS; i++) begin
      if (k < n) begin
        word[i] = (i == k);
      end else begin
        word[i] = (i < n) && (i != (k - n));
      end
    end
    return word;
  endfunction

endpackage

// File: rtl/pin_chain_tester_sync_bus.sv
// rtl/pin_chain_tester_sync_bus.sv - multi-bit flop chain synchroniser for asynchronous inputs
module sync_bus #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  // Shift the raw input through STAGES flops; only the last stage is used downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/pin_chain_tester.sv
// rtl/pin_chain_tester.sv - walking-one/zero sweep of the jig pin chain with per-link fail mask
module pin_chain_tester
  import pin_chain_pkg::*;
#(
  parameter int N_PINS        = N_CHAIN_PINS,
  parameter int SETTLE_CYCLES = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [N_PINS-1:0] pins_i,
  output logic [N_PINS-1:0] pins_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [N_PINS-1:0] fail_mask_o
);

  localparam int N_STEPS = 2 * N_PINS;
  localparam int STEP_W  = $clog2(N_STEPS);
  localparam int CNT_W   = $clog2(SETTLE_CYCLES);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(SETTLE_CYCLES - 1);

  logic [N_PINS-1:0] synced_pins;
  logic              synced_start;
  logic              start_q;
  logic              start_pulse;

  chain_state_e      state;
  chain_state_e      next_state;
  logic [STEP_W-1:0] step;
  logic [STEP_W-1:0] step_next;
  logic [CNT_W-1:0]  settle;
  logic [CNT_W-1:0]  settle_next;
  logic [N_PINS-1:0] fail_mask;
  logic [N_PINS-1:0] fail_mask_next;
  logic [N_PINS-1:0] pattern_now;

  sync_bus #(
    .WIDTH (N_PINS),
    .STAGES(SYNC_STAGES)
  ) u_sync_pins (
    .clk(clk),
    .rst(rst),
    .d  (pins_i),
    .q  (synced_pins)
  );

  sync_bus #(
    .WIDTH (1),
    .STAGES(SYNC_STAGES)
  ) u_sync_start (
    .clk(clk),
    .rst(rst),
    .d  (start_i),
    .q  (synced_start)
  );

  // Registered rising-edge detect: a held-high start yields exactly one pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q     <= 1'b0;
      start_pulse <= 1'b0;
    end else begin
      start_q     <= synced_start;
      start_pulse <= synced_start & ~start_q;
    end
  end

  assign pattern_now = N_PINS'(pattern(32'(step), N_PINS));

  // State, step/settle counters and the accumulated mismatch mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      step      <= '0;
      settle    <= '0;
      fail_mask <= '0;
    end else begin
      state     <= next_state;
      step      <= step_next;
      settle    <= settle_next;
      fail_mask <= fail_mask_next;
    end
  end

  // Sequencing: start only from IDLE/DONE, settle each pattern, then compare once.
  always_comb begin
    next_state     = state;
    step_next      = step;
    settle_next    = settle;
    fail_mask_next = fail_mask;
    case (state)
      IDLE, DONE: begin
        if (start_pulse) begin
          next_state     = DRIVE;
          step_next      = '0;
          settle_next    = '0;
          fail_mask_next = '0;
        end
      end
      DRIVE: begin
        if (settle == LAST_CNT) begin
          next_state = CHECK;
        end else begin
          settle_next = settle + CNT_W'(1);
        end
      end
      CHECK: begin
        fail_mask_next = fail_mask | (synced_pins ^ pattern_now);
        settle_next    = '0;
        if (step == LAST_STEP) begin
          next_state = DONE;
          step_next  = '0;
        end else begin
          next_state = DRIVE;
          step_next  = step + STEP_W'(1);
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Outputs are registered copies of the internal state so pass_o, done_o and
  // fail_mask_o always change on the same edge and never disagree.
  always_ff @(posedge clk) begin
    if (rst) begin
      pins_o      <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      fail_mask_o <= '0;
    end else begin
      pins_o      <= (state == DRIVE || state == CHECK) ? pattern_now : '0;
      busy_o      <= (state == DRIVE || state == CHECK);
      done_o      <= (state == DONE);
      pass_o      <= (state == DONE) && (fail_mask == '0);
      fail_mask_o <= fail_mask;
    end
  end

endmodule
